// File: rtl/kulisch_log_pkg.sv
// Shared definitions for the Kulisch accumulator to log-domain read-out path:
// default geometry, derived widths, exponent limits, the result record and
// the constant generator for the log2 mantissa table.
package kulisch_log_pkg;

   localparam int M                  = 5;
   localparam int F                  = 4;
   localparam int ACC_NON_FRAC       = 16;
   localparam int ACC_FRAC           = 16;
   localparam int LINEAR_TO_LOG_BITS = 8;
   localparam int SCAN_CHUNK         = 8;

   localparam int ACC_W   = ACC_NON_FRAC + ACC_FRAC;
   localparam int S       = (ACC_W + SCAN_CHUNK - 1) / SCAN_CHUNK;
   localparam int EXP_W   = M + F;
   localparam int EXP_MAX = (1 << (EXP_W - 1)) - 1;
   localparam int EXP_MIN = -(1 << (EXP_W - 1));

   // Wide enough to hold (2^lbits + x)^(2^(fbits+1)) for the default geometry
   localparam int T_POW_W = 512;

   typedef struct packed {
      logic             sign;
      logic             zero;
      logic             inf;
      logic [EXP_W-1:0] exp;
   } log_result_t;

   // T(x) = round-half-up(log2(1 + x/2^lbits) * 2^fbits), computed exactly:
   // with v = 2^lbits + x, floor(log2(v^(2^(fbits+1)))) - lbits*2^(fbits+1)
   // equals floor(2^(fbits+1) * log2(1 + x/2^lbits)), i.e. the log scaled by
   // one extra bit; adding one and halving gives the rounded table value.
   function automatic int t_value(input int x, input int lbits, input int fbits);
      logic [T_POW_W-1:0] p;
      int                 msb;
      p = T_POW_W'(x) + (T_POW_W'(1) << lbits);
      for (int i = 0; i < fbits + 1; i++) begin
         p = p * p;
      end
      msb = $clog2(p + T_POW_W'(1)) - 1;
      return (msb - lbits * (1 << (fbits + 1)) + 1) >>> 1;
   endfunction

endpackage

// File: rtl/linear_to_log_table.sv
// Combinational ROM mapping the mantissa bits below the leading one to the
// fractional log2 correction T(x). Entries are F+1 bits so T(x) = 2^F fits.
module linear_to_log_table
   import kulisch_log_pkg::*;
#(
   parameter int LBITS = LINEAR_TO_LOG_BITS,
   parameter int FBITS = F
) (
   input  logic [LBITS-1:0] x,
   output logic [FBITS:0]   t
);

   logic [FBITS:0] rom [2**LBITS];

   for (genvar gi = 0; gi < 2**LBITS; gi++) begin : g_rom
      localparam logic [FBITS:0] TV = (FBITS + 1)'(t_value(gi, LBITS, FBITS));
      assign rom[gi] = TV;
   end

   assign t = rom[x];

endmodule

// File: rtl/kulisch_to_log_convert.sv
// Converts a finished two's-complement Kulisch accumulator into an unpacked
// log-domain number. One conversion at a time with a fixed S+3 cycle latency:
// ABS -> SCAN (S cycles, chunked leading-one search) -> NORM -> LUT -> DONE.
module kulisch_to_log_convert #(
   parameter int M                  = kulisch_log_pkg::M,
   parameter int F                  = kulisch_log_pkg::F,
   parameter int ACC_NON_FRAC       = kulisch_log_pkg::ACC_NON_FRAC,
   parameter int ACC_FRAC           = kulisch_log_pkg::ACC_FRAC,
   parameter int LINEAR_TO_LOG_BITS = kulisch_log_pkg::LINEAR_TO_LOG_BITS,
   parameter int SCAN_CHUNK         = kulisch_log_pkg::SCAN_CHUNK,
   parameter int SATURATE_MAX       = 1
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [ACC_NON_FRAC+ACC_FRAC-1:0]     acc_in,
   input  logic                                 acc_overflow,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic                                 out_sign,
   output logic                                 out_zero,
   output logic                                 out_inf,
   output logic [M+F-1:0]                       out_exp
);

   import kulisch_log_pkg::*;

   localparam int AW    = ACC_NON_FRAC + ACC_FRAC;
   localparam int NS    = (AW + SCAN_CHUNK - 1) / SCAN_CHUNK;
   localparam int SW    = NS * SCAN_CHUNK;
   localparam int PAD   = SW - AW;
   localparam int PW    = $clog2(AW);
   localparam int CW    = $clog2(NS + 1);
   localparam int EW    = M + F;
   localparam int LB    = LINEAR_TO_LOG_BITS;
   localparam int E_MAX = (1 << (EW - 1)) - 1;
   localparam int E_MIN = -(1 << (EW - 1));

   localparam logic [EW-1:0] EXP_MAX_V = EW'(E_MAX);
   localparam logic [EW-1:0] EXP_MIN_V = EW'(E_MIN);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ABS  = 3'd1;
   localparam logic [2:0] ST_SCAN = 3'd2;
   localparam logic [2:0] ST_NORM = 3'd3;
   localparam logic [2:0] ST_LUT  = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

   logic [2:0]    state_reg;
   logic [AW-1:0] acc_reg;
   logic          ovf_reg;
   logic          sign_reg;
   logic [AW-1:0] mag_reg;
   logic [SW-1:0] scan_reg;
   logic [CW-1:0] cnt_reg;
   logic          found_reg;
   logic [PW-1:0] pos_reg;
   logic [LB-1:0] x_reg;
   log_result_t   result_reg;

   logic [AW-1:0] mag_next;
   logic          chunk_hit;
   logic [PW-1:0] chunk_pos;
   logic [AW-1:0] norm_shift;
   logic [LB-1:0] x_next;
   logic [F:0]    t_val;
   int            exp_full;
   log_result_t   result_next;

   // Magnitude of the captured accumulator; the most negative value maps to
   // 2^(AW-1), which still fits as an unsigned AW-bit number
   always_comb begin
      mag_next = acc_reg[AW-1] ? ((~acc_reg) + AW'(1)) : acc_reg;
   end

   // Highest set bit within the chunk currently at the top of the scan window,
   // translated back to a bit position of the magnitude
   always_comb begin
      chunk_hit = 1'b0;
      chunk_pos = '0;
      for (int k = SCAN_CHUNK - 1; k >= 0; k--) begin
         if (!chunk_hit && scan_reg[SW-SCAN_CHUNK+k]) begin
            chunk_hit = 1'b1;
            chunk_pos = PW'(AW - SCAN_CHUNK + k - int'(cnt_reg) * SCAN_CHUNK);
         end
      end
   end

   // Move the leading one to the MSB; the next LB bits form the table index,
   // with zeros shifted in when fewer bits exist below the leading one
   always_comb begin
      norm_shift = mag_reg << (PW'(AW - 1) - pos_reg);
      x_next     = LB'(norm_shift >> (AW - 1 - LB));
   end

   linear_to_log_table #(
      .LBITS (LB),
      .FBITS (F)
   ) u_table (
      .x (x_reg),
      .t (t_val)
   );

   // Full-range exponent, then the special cases in priority order:
   // overflow, zero, too large, too small
   always_comb begin
      exp_full    = (int'(pos_reg) - ACC_FRAC) * (1 << F) + int'(t_val);
      result_next = '0;
      if (ovf_reg || (found_reg && exp_full > E_MAX)) begin
         result_next.sign = sign_reg;
         if (SATURATE_MAX != 0) begin
            result_next.exp = EXP_MAX_V;
         end else begin
            result_next.inf = 1'b1;
         end
      end else if (!found_reg) begin
         result_next.zero = 1'b1;
      end else if (exp_full < E_MIN) begin
         result_next.sign = sign_reg;
         result_next.exp  = EXP_MIN_V;
      end else begin
         result_next.sign = sign_reg;
         result_next.exp  = EW'(exp_full);
      end
   end

   // Conversion sequencer and datapath registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         acc_reg    <= '0;
         ovf_reg    <= 1'b0;
         sign_reg   <= 1'b0;
         mag_reg    <= '0;
         scan_reg   <= '0;
         cnt_reg    <= '0;
         found_reg  <= 1'b0;
         pos_reg    <= '0;
         x_reg      <= '0;
         result_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (in_valid) begin
                  acc_reg   <= acc_in;
                  ovf_reg   <= acc_overflow;
                  state_reg <= ST_ABS;
               end
            end
            ST_ABS: begin
               sign_reg  <= acc_reg[AW-1];
               mag_reg   <= mag_next;
               scan_reg  <= SW'(mag_next) << PAD;
               cnt_reg   <= '0;
               found_reg <= 1'b0;
               pos_reg   <= '0;
               state_reg <= ST_SCAN;
            end
            ST_SCAN: begin
               if (!found_reg && chunk_hit) begin
                  found_reg <= 1'b1;
                  pos_reg   <= chunk_pos;
               end
               scan_reg <= scan_reg << SCAN_CHUNK;
               cnt_reg  <= cnt_reg + CW'(1);
               if (cnt_reg == CW'(NS - 1)) begin
                  state_reg <= ST_NORM;
               end
            end
            ST_NORM: begin
               x_reg     <= x_next;
               state_reg <= ST_LUT;
            end
            ST_LUT: begin
               result_reg <= result_next;
               state_reg  <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_reg == ST_IDLE);
   assign out_valid = (state_reg == ST_DONE);
   assign out_sign  = result_reg.sign;
   assign out_zero  = result_reg.zero;
   assign out_inf   = result_reg.inf;
   assign out_exp   = result_reg.exp;

endmodule
